parity_frame_checker: RTL
=========================

// Module: parity_frame_checker
// PURPOSE
//   Parametrised, sequential successor to the 3-input XNOR parity chain.
//   Folds WIDTH-bit words into one parity bit over a frame of FRAME_LEN words,
//   using a valid/ready handshake on both input and output.
//   Compares the result with an expected parity bit and flags a mismatch.
//   Sits between a word source (UART RX, switch bank) and status LEDs/logger.
// PARAMETERS
//   WIDTH     8  data word width in bits (>=1)
//   FRAME_LEN 4  words per frame (>=1)
//   ODD       0  0: even parity (XOR of all bits); 1: odd parity (XNOR, inverted)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data/in_exp valid
//   in_ready   out  1      block can accept a word
//   in_data    in   WIDTH  data word
//   in_exp     in   1      expected frame parity; sampled only on the last word's beat
//   abort      in   1      synchronous frame discard
//   out_valid  out  1      frame result valid
//   out_ready  in   1      consumer takes result
//   out_parity out  1      computed frame parity
//   out_error  out  1      out_parity != sampled in_exp
//   word_cnt   out  CW     words accepted in current frame, CW = max(1,$clog2(FRAME_LEN+1))
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, acc=0, word_cnt=0, exp_q=0,
//     out_valid=0, out_parity=0, out_error=0; in_ready=1 once rst_n releases.
//     Reset asserted mid-frame or mid-DONE discards everything immediately.
//   Beat: in_valid & in_ready at the rising edge. Word parity p = ^in_data.
//   States:
//     IDLE : in_ready=1. On a beat: acc<=p, word_cnt<=1, go to ACCUM;
//            if FRAME_LEN==1, go directly to DONE instead (see last-beat rule).
//     ACCUM: in_ready=1. On a beat: acc<=acc^p, word_cnt<=word_cnt+1.
//            Last beat = word_cnt==FRAME_LEN-1: latch exp_q<=in_exp, go to DONE.
//     DONE : in_ready=0, out_valid=1;
//            out_parity = acc ^ ODD, out_error = out_parity ^ exp_q (registered).
//            On out_valid & out_ready: acc=0, word_cnt=0, out_valid=0, go to IDLE.
//   Latency: result is valid on the cycle after the last input beat.
//     Holding out_ready=1 gives one-cycle throughput gap between frames
//     (no accept in DONE).
//   Output stability: out_* are held constant while out_valid=1 and out_ready=0.
//   abort: in IDLE/ACCUM, go to IDLE with acc=0 and word_cnt=0; an input beat in
//     the same cycle is dropped (abort wins). In DONE, abort is ignored and the
//     result must be consumed.
//   in_valid=0 gaps mid-frame: state and acc hold; no timeout.
//   in_exp is ignored on every beat except the last.
//   No combinational path from in_valid to in_ready, or from out_ready to out_valid.
// TESTING (WIDTH=8, FRAME_LEN=4, ODD=0 unless stated)
//   1 Words 01,03,00,FF back-to-back, in_exp=1 on last -> next cycle
//     out_valid=1, out_parity=1, out_error=0.
//   2 Same words, in_exp=0 -> out_parity=1, out_error=1. Hold out_ready=0 for
//     5 cycles -> outputs stable, in_ready=0 throughout.
//   3 ODD=1, words 00,00,00,00, in_exp=1 -> out_parity=1, out_error=0.
//   4 Two words, then abort together with a valid 3rd word -> word_cnt=0, IDLE.
//     A new 4-word frame 80,00,00,00 -> out_parity=1.
//   5 rst_n low after 3 accepted words -> all outputs 0 asynchronously.
//     After release, a full 4-word frame gives a correct result (no stale acc).
//   6 FRAME_LEN=1, WIDTH=3, all 8 inputs with random in_valid/out_ready
//     -> out_parity matches ~(a^b^c) with ODD=1 and a^b^c with ODD=0
//        (scoreboard).

Source files
------------

// File: rtl/parity_frame_checker.sv
// Folds FRAME_LEN words of WIDTH bits into one parity bit, compares it with an
// expected bit sampled on the last word, and hands the result out over valid/ready.
module parity_frame_checker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  localparam int CW = ($clog2(FRAME_LEN + 1) > 1) ? $clog2(FRAME_LEN + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_exp,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CW-1:0]    word_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic          ODD_BIT  = (ODD != 0);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_t          state, state_d;
  logic            acc, acc_d;
  logic [CW-1:0]   cnt_d;
  logic            exp_q, exp_d;
  logic            par_d;
  logic            word_par;
  logic            last_beat;

  assign word_par  = ^in_data;
  // IDLE holds word_cnt at 0, so this also marks the single beat when FRAME_LEN==1.
  assign last_beat = (word_cnt == LAST_CNT);

  // Both handshake outputs come from the state register only, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = rst_n & (state != DONE);
  assign out_valid = (state == DONE);
  assign out_error = out_parity ^ exp_q;

  // NOTE: every variable gets its hold value before the case so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = word_cnt;
    exp_d   = exp_q;
    par_d   = out_parity;
    unique case (state)
      IDLE, ACCUM: begin
        if (abort) begin
          state_d = IDLE;
          acc_d   = 1'b0;
          cnt_d   = '0;
        end else if (in_valid) begin
          acc_d = acc ^ word_par;
          cnt_d = word_cnt + 1'b1;
          if (last_beat) begin
            exp_d   = in_exp;
            par_d   = acc_d ^ ODD_BIT;
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // abort is deliberately ignored here: a finished frame must be consumed.
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      word_cnt   <= '0;
      exp_q      <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      word_cnt   <= cnt_d;
      exp_q      <= exp_d;
      out_parity <= par_d;
    end
  end

endmodule
